// File: rtl/mem_preloader_if.sv
// Byte-stream input and external memory write port of the memory preloader.
interface mem_preloader_if;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  logic              in_valid;
  logic [BYTE_W-1:0] in_byte;
  logic              in_ready;
  logic              reload;
  logic              ext_mem_write;
  logic [WORD_W-1:0] ext_wrdata_add;
  logic [WORD_W-1:0] ext_wrdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  // Stream source / status consumer side
  modport master (
    output in_valid, in_byte, reload,
    input  in_ready, ext_mem_write, ext_wrdata_add, ext_wrdata,
           cpu_hold, done, error
  );

  // Loader side
  modport slave (
    input  in_valid, in_byte, reload,
    output in_ready, ext_mem_write, ext_wrdata_add, ext_wrdata,
           cpu_hold, done, error
  );
endinterface

// File: rtl/mem_preloader.sv
// Framed byte-stream loader: base address, word count, little-endian words,
// and (with PRELOADER_CHECKSUM_EN defined) a trailing XOR checksum byte.
// Emits one-cycle external memory write pulses and holds the CPU in reset
// until the frame has been loaded.
module mem_preloader #(
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic           clk,
  input  logic           reset,
  mem_preloader_if.slave bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned SR_W   = WORD_W - BYTE_W;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [2:0] {
    ST_ADDR,
    ST_COUNT,
    ST_DATA,
`ifdef PRELOADER_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE,
    ST_ERR
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  byte_idx;
  logic [SR_W-1:0]   word_sr;
  logic [WORD_W-1:0] next_addr;
  logic [WORD_W-1:0] words_left;
  logic              release_pending;

  logic              accept;
  logic              last_byte;
  logic              reload_take;
  logic [WORD_W-1:0] word_full;

  // Byte handshake and little-endian word assembly
  always_comb begin
    accept      = bus.in_valid && bus.in_ready;
    last_byte   = accept && (byte_idx == IDX_W'(3));
    word_full   = {bus.in_byte, word_sr};
    reload_take = bus.reload && !release_pending &&
                  ((state == ST_DONE) || (state == ST_ERR));
  end

`ifdef PRELOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
  logic              csum_ok;

  // Running XOR of every header and data byte
  always_ff @(posedge clk) begin
    if (!reset) begin
      csum <= '0;
    end else if (reload_take) begin
      csum <= '0;
    end else if (accept && (state != ST_CSUM)) begin
      csum <= csum ^ bus.in_byte;
    end
  end

  // Checksum byte comparison
  always_comb begin
    csum_ok = (bus.in_byte == csum);
  end
`endif

  // Frame sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= ST_ADDR;
      byte_idx           <= '0;
      word_sr            <= '0;
      next_addr          <= '0;
      words_left         <= '0;
      release_pending    <= 1'b0;
      bus.in_ready       <= 1'b0;
      bus.ext_mem_write  <= 1'b0;
      bus.ext_wrdata_add <= '0;
      bus.ext_wrdata     <= '0;
      bus.cpu_hold       <= 1'b1;
      bus.done           <= 1'b0;
      bus.error          <= 1'b0;
    end else begin
      bus.ext_mem_write <= 1'b0;
      if (accept) begin
        word_sr  <= word_full[WORD_W-1:BYTE_W];
        byte_idx <= byte_idx + IDX_W'(1);
      end

      case (state)
        ST_ADDR: begin
          bus.in_ready <= 1'b1;
          if (last_byte) begin
            next_addr <= word_full;
            state     <= ST_COUNT;
          end
        end

        ST_COUNT: begin
          if (last_byte) begin
            words_left <= word_full;
            if (word_full > WORD_W'(MAX_WORDS)) begin
              state        <= ST_ERR;
              bus.in_ready <= 1'b0;
              bus.error    <= 1'b1;
            end else if (word_full == '0) begin
`ifdef PRELOADER_CHECKSUM_EN
              state        <= ST_CSUM;
`else
              state        <= ST_DONE;
              bus.in_ready <= 1'b0;
              bus.cpu_hold <= 1'b0;
              bus.done     <= 1'b1;
`endif
            end else begin
              state <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (last_byte) begin
            bus.ext_mem_write  <= 1'b1;
            bus.ext_wrdata     <= word_full;
            bus.ext_wrdata_add <= next_addr;
            next_addr          <= next_addr + WORD_W'(ADDR_STEP);
            words_left         <= words_left - WORD_W'(1);
            if (words_left == WORD_W'(1)) begin
`ifdef PRELOADER_CHECKSUM_EN
              state           <= ST_CSUM;
`else
              // Release waits one cycle so the hold covers the final write
              state           <= ST_DONE;
              bus.in_ready    <= 1'b0;
              release_pending <= 1'b1;
`endif
            end
          end
        end

`ifdef PRELOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (accept) begin
            bus.in_ready <= 1'b0;
            if (csum_ok) begin
              state        <= ST_DONE;
              bus.cpu_hold <= 1'b0;
              bus.done     <= 1'b1;
            end else begin
              state     <= ST_ERR;
              bus.error <= 1'b1;
            end
          end
        end
`endif

        ST_DONE: begin
          if (release_pending) begin
            release_pending <= 1'b0;
            bus.cpu_hold    <= 1'b0;
            bus.done        <= 1'b1;
          end else if (reload_take) begin
            state        <= ST_ADDR;
            byte_idx     <= '0;
            bus.in_ready <= 1'b1;
            bus.cpu_hold <= 1'b1;
            bus.done     <= 1'b0;
          end
        end

        ST_ERR: begin
          if (reload_take) begin
            state        <= ST_ADDR;
            byte_idx     <= '0;
            bus.in_ready <= 1'b1;
            bus.error    <= 1'b0;
          end
        end

        default: begin
          state <= ST_ERR;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_preloader.md
# mem_preloader

Byte-stream loader that sits directly upstream of the CPU top's external memory write port. It takes a framed byte stream: base address, word count, little-endian 32-bit words, and an optional checksum. It turns the stream into single-cycle external data-memory write pulses, holding the CPU in reset for the whole load. When the load completes it releases the CPU; on a malformed frame it keeps the CPU held and flags an error.

## Interface
Parameters:
- ADDR_STEP, 4, byte-address increment per word written
- MAX_WORDS, 1024, largest legal word count; larger counts are an error

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low; sampled on clk rising edge
- in_valid  input  1  in_byte is valid this cycle
- in_byte  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready
- reload  input  1  single-cycle request to start a new frame; honoured only in DONE or ERR
- ext_mem_write  output  1  one-cycle write strobe to the CPU top external write port
- ext_wrdata_add  output  32  write byte address
- ext_wrdata  output  32  write data
- cpu_hold  output  1  active-high hold, drives the CPU top reset input
- done  output  1  load completed successfully (level)
- error  output  1  frame rejected (level)

## Operation
- States: ADDR, COUNT, DATA, CSUM (only with macro), DONE, ERR.
- ADDR: collect 4 bytes, little-endian, into base. After the 4th byte go to COUNT.
- COUNT: collect 4 bytes into cnt.
  - cnt > MAX_WORDS: go to ERR.
  - cnt == 0: go to CSUM if the macro is defined, else DONE.
  - Otherwise go to DATA with idx = 0.
- DATA:
  - Assemble 4 bytes, little-endian; byte 0 goes to bits [7:0].
  - On the 4th byte, register ext_wrdata = word and ext_wrdata_add = base + idx*ADDR_STEP, computed mod 2^32 so the address wraps silently.
  - Pulse ext_mem_write for the following cycle, then increment idx.
  - After word cnt-1 go to CSUM if the macro is defined, else DONE.
- CSUM: see Configuration.
- DONE: cpu_hold=0, done=1, in_ready=0.
- ERR: cpu_hold=1, error=1, in_ready=0.
- From DONE or ERR, reload=1 moves to ADDR with cpu_hold=1, done=0, error=0. reload is ignored in all other states.
- in_ready=1 in ADDR, COUNT, DATA and CSUM. Bytes presented with in_valid=0 are never consumed.
- Memory already written is never rolled back on error or reset.

## Timing
- All outputs are registered.
- Values while reset is low and on the first cycle after release:
  - state=ADDR, cpu_hold=1, ext_mem_write=0, ext_wrdata_add=0, ext_wrdata=0, done=0, error=0.
  - in_ready=0 while reset is low, 1 from the first cycle after release.
- Write latency: accept of the 4th byte of a word in cycle N gives ext_mem_write=1 in cycle N+1 only. Address and data are stable in N+1 and hold their values until the next write.
- Back-to-back bytes: in_ready stays 1 during the write pulse. A byte accepted in cycle N+1 belongs to the next word. Throughput is 1 byte/cycle, so the minimum write spacing is 4 cycles.
- Release:
  - The final write pulse occurs in cycle N+1.
  - Without the macro, DONE is entered with cpu_hold=0 and done=1 in cycle N+2. cpu_hold is never low during a write.
  - With the macro, the same applies counted from checksum acceptance.
- ERR is entered the cycle after the offending byte is accepted.
- reload=1 in DONE/ERR gives ADDR, in_ready=1 and cpu_hold=1 the next cycle.
- Reset low mid-frame aborts immediately on that edge, regardless of in_valid or reload. A pending write pulse is cancelled.
- reload and reset asserted together: reset wins.

## Configuration
- PRELOADER_CHECKSUM_EN defined:
  - A running 8-bit XOR covers every byte accepted in ADDR, COUNT and DATA.
  - CSUM accepts one byte. If it equals the XOR, go to DONE, else go to ERR.
  - The XOR clears on reset and on reload.
- Not defined: CSUM state and XOR logic are absent. The frame ends after the last data byte, or after the count field when cnt == 0.

## Test plan
- Two-word load, macro off:
  - Stimulus: stream 00 10 00 00 | 02 00 00 00 | 78 56 34 12 | EF BE AD DE, one byte per cycle.
  - Required: writes 0x00001000←0x12345678, then 0x00001004←0xDEADBEEF, each exactly one cycle wide. cpu_hold falls 1 cycle after the second write; done=1.
- Count overflow:
  - Stimulus: count 0x00000401 with MAX_WORDS=1024.
  - Required: no write; error=1 and cpu_hold=1 one cycle after the 4th count byte. Then reload returns to ADDR and a valid frame loads correctly.
- Throttled and wrapping input:
  - Stimulus: randomly toggle in_valid, with base 0xFFFFFFFC and count 2.
  - Required: addresses 0xFFFFFFFC, then 0x00000000, with data identical to the unthrottled run.
- Reset mid-frame:
  - Stimulus: drive reset low after 2 bytes of word 1.
  - Required: no write pulse follows; all outputs take their reset values; the next frame starts at ADDR.
- Checksum, macro on:
  - Stimulus: the two-word frame above plus a checksum byte equal to the XOR of all 16 bytes.
  - Required: done=1.
  - Stimulus: the same frame with the checksum byte flipped.
  - Required: both writes still occur, then error=1 and cpu_hold stays 1.
- Zero count:
  - Stimulus: count 0.
  - Required: no writes; done=1 the cycle after the last count byte (macro off).
